// File: rtl/team_09_wb_master.sv
// Single-transaction Wishbone master: one request becomes one bus cycle, then one response.
// Define TEAM_09_WBM_TIMEOUT_EN to abort bus cycles that see no ACK_I within TIMEOUT_CYCLES.
module team_09_wb_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_adr,
    input  logic [31:0] req_dat,
    input  logic [3:0]  req_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic [31:0] ADR_O,
    output logic [31:0] DAT_O,
    output logic [3:0]  SEL_O,
    output logic        WE_O,
    output logic        STB_O,
    output logic        CYC_O,
    input  logic [31:0] DAT_I,
    input  logic        ACK_I,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; the
    // producer holds valid and payload until that edge, ready never depends on valid.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;

`ifdef TEAM_09_WBM_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
    logic [15:0] to_cnt;
    logic [15:0] to_cnt_next;
    assign to_cnt_next = to_cnt + 16'd1;
`endif

    // Word-aligned addressing drops the low address bits.
    logic unused_bits;
    assign unused_bits = &{1'b0, req_adr[1:0], (TIMEOUT_CYCLES > 0)};

    assign state_dbg = state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_dat   <= 32'h0;
            rsp_err   <= 1'b0;
            ADR_O     <= 32'h0;
            DAT_O     <= 32'h0;
            SEL_O     <= 4'h0;
            WE_O      <= 1'b0;
            STB_O     <= 1'b0;
            CYC_O     <= 1'b0;
`ifdef TEAM_09_WBM_TIMEOUT_EN
            to_cnt    <= 16'h0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (req_sel == 4'h0) begin
                            // No byte lanes: fail without touching the bus.
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_dat   <= 32'h0;
                        end else begin
                            state <= BUS;
                            CYC_O <= 1'b1;
                            STB_O <= 1'b1;
                            WE_O  <= req_we;
                            ADR_O <= {req_adr[31:2], 2'b00};
                            DAT_O <= req_we ? req_dat : 32'h0;
                            SEL_O <= req_sel;
`ifdef TEAM_09_WBM_TIMEOUT_EN
                            to_cnt <= 16'h0;
`endif
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end

                BUS: begin
                    if (ACK_I) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_dat   <= WE_O ? 32'h0 : DAT_I;
                        CYC_O     <= 1'b0;
                        STB_O     <= 1'b0;
                        WE_O      <= 1'b0;
                        ADR_O     <= 32'h0;
                        DAT_O     <= 32'h0;
                        SEL_O     <= 4'h0;
                    end
`ifdef TEAM_09_WBM_TIMEOUT_EN
                    // ACK_I on the limit cycle takes the branch above and wins.
                    else if (to_cnt_next == TO_LIMIT) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_dat   <= 32'h0;
                        CYC_O     <= 1'b0;
                        STB_O     <= 1'b0;
                        WE_O      <= 1'b0;
                        ADR_O     <= 32'h0;
                        DAT_O     <= 32'h0;
                        SEL_O     <= 4'h0;
                    end else begin
                        to_cnt <= to_cnt_next;
                    end
`endif
                end

                RESP: begin
                    if (rsp_ready) begin
                        // Ready goes high with the return to IDLE, never during the handshake.
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        rsp_valid <= 1'b0;
                        rsp_dat   <= 32'h0;
                        rsp_err   <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                    busy      <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
